// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request/response and memory-side handshake bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] i_data;
  logic [WORD_W-1:0] d_rdata;
  logic              i_done;
  logic              d_done;
  logic              i_stall;
  logic              d_stall;
  logic              mem_error;

  modport slave (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_ready, mem_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, i_data, d_rdata,
           i_done, d_done, i_stall, d_stall, mem_error
  );

  modport master (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, mem_ready, mem_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, i_data, d_rdata,
           i_done, d_done, i_stall, d_stall, mem_error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and data access; data wins, one transaction at a time.
// Define MEM_ARB_STATS_EN to add saturating stall-cycle counters num_i_stall / num_d_stall.
module mem_port_arbiter #(
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] num_i_stall,
  output logic [15:0] num_d_stall
`endif
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_W-1:0] i_data_q, i_data_d;
  logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              mem_error_q, mem_error_d;
  logic              d_req_v, i_req_v, timeout_hit;
  logic              i_stall, d_stall;

  // A request is still held high during its own done cycle; mask it so it cannot re-issue.
  assign d_req_v     = (bus.d_read | bus.d_write) & ~d_done_q;
  assign i_req_v     = bus.i_req & ~i_done_q;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_data_d    = i_data_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    mem_error_d = mem_error_q;
    case (state_q)
      IDLE: begin
        if (d_req_v) begin
          mem_addr_d  = bus.d_addr;
          mem_read_d  = bus.d_read;
          mem_write_d = bus.d_write;
          mem_wdata_d = bus.d_write ? bus.d_wdata : '0;
          cnt_d       = '0;
          state_d     = D_BUSY;
        end else if (i_req_v) begin
          mem_addr_d = bus.i_addr;
          mem_read_d = 1'b1;
          cnt_d      = '0;
          state_d    = I_BUSY;
        end
      end
      D_BUSY, I_BUSY: begin
        if (bus.mem_ready || timeout_hit) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_wdata_d = '0;
          if (!bus.mem_ready) mem_error_d = 1'b1;
          // An abort returns zero data; a completed store leaves d_rdata untouched.
          if (state_q == D_BUSY) begin
            d_done_d = 1'b1;
            if (!bus.mem_ready)  d_rdata_d = '0;
            else if (mem_read_q) d_rdata_d = bus.mem_rdata;
          end else begin
            i_done_d = 1'b1;
            i_data_d = bus.mem_ready ? bus.mem_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_data_q    <= i_data_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign i_stall       = bus.i_req & ~i_done_q;
  assign d_stall       = (bus.d_read | bus.d_write) & ~d_done_q;
  assign bus.i_stall   = i_stall;
  assign bus.d_stall   = d_stall;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_data    = i_data_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.mem_error = mem_error_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] num_i_stall_q, num_d_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_i_stall_q <= '0;
      num_d_stall_q <= '0;
    end else begin
      if (i_stall && num_i_stall_q != 16'hFFFF) num_i_stall_q <= num_i_stall_q + 16'd1;
      if (d_stall && num_d_stall_q != 16'hFFFF) num_d_stall_q <= num_d_stall_q + 16'd1;
    end
  end

  assign num_i_stall = num_i_stall_q;
  assign num_d_stall = num_d_stall_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=8); each task drives one scenario and checks inline.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mem_port_arbiter_if #(.WORD_W(16), .ADDR_W(16)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] num_i_stall;
  logic [15:0] num_d_stall;
  mem_port_arbiter #(.WORD_W(16), .ADDR_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .num_i_stall(num_i_stall), .num_d_stall(num_d_stall)
  );
`else
  mem_port_arbiter #(.WORD_W(16), .ADDR_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 0; bus.mem_rdata = '0;
    #12;
    n_cmp++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== 34'h0) begin
      n_err++; $display("FAIL reset_mem: got %h want 0", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata});
    end
    n_cmp++;
    if ({bus.i_data, bus.d_rdata, bus.i_done, bus.d_done, bus.mem_error, bus.i_stall, bus.d_stall} !== 37'h0) begin
      n_err++; $display("FAIL reset_out: got %h want 0",
        {bus.i_data, bus.d_rdata, bus.i_done, bus.d_done, bus.mem_error, bus.i_stall, bus.d_stall});
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    bus.i_req = 1; bus.i_addr = 16'h0010;
    #1;
    n_cmp++;
    if (bus.i_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_req: got %b want 1", bus.i_stall); end
    tick();
    n_cmp++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.i_stall, bus.i_done} !== {1'b1, 1'b0, 16'h0010, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL fetch_strobe: got %h want %h",
        {bus.mem_read, bus.mem_write, bus.mem_addr, bus.i_stall, bus.i_done}, {1'b1, 1'b0, 16'h0010, 1'b1, 1'b0});
    end
    bus.mem_ready = 1; bus.mem_rdata = 16'h6A05;
    tick();
    bus.mem_ready = 0;
    n_cmp++;
    if ({bus.i_done, bus.i_data, bus.mem_read, bus.i_stall, bus.d_done} !== {1'b1, 16'h6A05, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL fetch_done: got %h want %h",
        {bus.i_done, bus.i_data, bus.mem_read, bus.i_stall, bus.d_done}, {1'b1, 16'h6A05, 1'b0, 1'b0, 1'b0});
    end
    tick();
    bus.i_req = 0;
    n_cmp++;
    if ({bus.i_done, bus.mem_read} !== 2'b00) begin
      n_err++; $display("FAIL fetch_no_reissue: got %b want 00", {bus.i_done, bus.mem_read});
    end
    tick();
  endtask

  task automatic test_stats();
`ifdef MEM_ARB_STATS_EN
    n_cmp++;
    if ({num_i_stall, num_d_stall} !== {16'd4, 16'd0}) begin
      n_err++; $display("FAIL stats: got i=%0d d=%0d want i=4 d=0", num_i_stall, num_d_stall);
    end
`endif
  endtask

  task automatic test_priority();
    bus.i_req = 1; bus.i_addr = 16'h0020; bus.d_read = 1; bus.d_addr = 16'h0080;
    #1;
    n_cmp++;
    if ({bus.i_stall, bus.d_stall} !== 2'b11) begin
      n_err++; $display("FAIL prio_stall_req: got %b want 11", {bus.i_stall, bus.d_stall});
    end
    tick();
    n_cmp++;
    if ({bus.mem_read, bus.mem_addr} !== {1'b1, 16'h0080}) begin
      n_err++; $display("FAIL prio_data_first: got %h want %h", {bus.mem_read, bus.mem_addr}, {1'b1, 16'h0080});
    end
    bus.mem_ready = 1; bus.mem_rdata = 16'h1234;
    tick();
    bus.mem_ready = 0;
    n_cmp++;
    if ({bus.d_done, bus.d_rdata, bus.i_done, bus.mem_read, bus.d_stall, bus.i_stall} !==
        {1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL prio_d_done: got %h want %h",
        {bus.d_done, bus.d_rdata, bus.i_done, bus.mem_read, bus.d_stall, bus.i_stall},
        {1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    tick();
    bus.d_read = 0;
    n_cmp++;
    if ({bus.mem_read, bus.mem_addr, bus.d_done} !== {1'b1, 16'h0020, 1'b0}) begin
      n_err++; $display("FAIL prio_fetch_issue: got %h want %h", {bus.mem_read, bus.mem_addr, bus.d_done}, {1'b1, 16'h0020, 1'b0});
    end
    bus.mem_ready = 1; bus.mem_rdata = 16'h5678;
    tick();
    bus.mem_ready = 0;
    n_cmp++;
    if ({bus.i_done, bus.i_data, bus.d_done} !== {1'b1, 16'h5678, 1'b0}) begin
      n_err++; $display("FAIL prio_i_done: got %h want %h", {bus.i_done, bus.i_data, bus.d_done}, {1'b1, 16'h5678, 1'b0});
    end
    tick();
    bus.i_req = 0;
    tick();
  endtask

  task automatic test_write_wait();
    bus.d_write = 1; bus.d_addr = 16'h0042; bus.d_wdata = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata, bus.d_done, bus.d_stall} !==
          {1'b1, 1'b0, 16'h0042, 16'hBEEF, 1'b0, 1'b1}) begin
        n_err++; $display("FAIL write_hold[%0d]: got %h want %h", k,
          {bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata, bus.d_done, bus.d_stall},
          {1'b1, 1'b0, 16'h0042, 16'hBEEF, 1'b0, 1'b1});
      end
      if (k == 3) bus.mem_ready = 1;
    end
    tick();
    bus.mem_ready = 0;
    n_cmp++;
    if ({bus.d_done, bus.mem_write, bus.mem_wdata, bus.d_stall, bus.d_rdata} !==
        {1'b1, 1'b0, 16'h0000, 1'b0, 16'h1234}) begin
      n_err++; $display("FAIL write_done: got %h want %h",
        {bus.d_done, bus.mem_write, bus.mem_wdata, bus.d_stall, bus.d_rdata}, {1'b1, 1'b0, 16'h0000, 1'b0, 16'h1234});
    end
    tick();
    bus.d_write = 0;
    n_cmp++;
    if ({bus.d_done, bus.mem_write} !== 2'b00) begin
      n_err++; $display("FAIL write_single_pulse: got %b want 00", {bus.d_done, bus.mem_write});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.d_read = 1; bus.d_addr = 16'h0090;
    tick();
    n_cmp++;
    if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL rst_mid_issue: got %b want 1", bus.mem_read); end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
      n_err++; $display("FAIL rst_mid_async: got %b want 00", {bus.mem_read, bus.mem_write});
    end
    tick();
    n_cmp++;
    if (bus.d_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_done: got %b want 0", bus.d_done); end
    #2 reset = 1'b0;
    tick();
    n_cmp++;
    if ({bus.mem_read, bus.mem_addr, bus.d_done} !== {1'b1, 16'h0090, 1'b0}) begin
      n_err++; $display("FAIL rst_mid_reissue: got %h want %h", {bus.mem_read, bus.mem_addr, bus.d_done}, {1'b1, 16'h0090, 1'b0});
    end
    bus.mem_ready = 1; bus.mem_rdata = 16'hAAAA;
    tick();
    bus.mem_ready = 0;
    n_cmp++;
    if ({bus.d_done, bus.d_rdata} !== {1'b1, 16'hAAAA}) begin
      n_err++; $display("FAIL rst_mid_done: got %h want %h", {bus.d_done, bus.d_rdata}, {1'b1, 16'hAAAA});
    end
    tick();
    bus.d_read = 0;
    tick();
  endtask

  task automatic test_timeout();
    bus.i_req = 1; bus.i_addr = 16'h0030; bus.mem_rdata = 16'h7777;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if ({bus.mem_read, bus.i_done, bus.mem_error} !== 3'b100) begin
        n_err++; $display("FAIL timeout_busy[%0d]: got %b want 100", k, {bus.mem_read, bus.i_done, bus.mem_error});
      end
    end
    tick();
    n_cmp++;
    if ({bus.i_done, bus.i_data, bus.mem_error, bus.mem_read} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL timeout_abort: got %h want %h",
        {bus.i_done, bus.i_data, bus.mem_error, bus.mem_read}, {1'b1, 16'h0000, 1'b1, 1'b0});
    end
    tick();
    bus.i_req = 0;
    tick();
    bus.i_req = 1; bus.i_addr = 16'h0040;
    tick();
    n_cmp++;
    if ({bus.mem_read, bus.mem_addr} !== {1'b1, 16'h0040}) begin
      n_err++; $display("FAIL timeout_next_issue: got %h want %h", {bus.mem_read, bus.mem_addr}, {1'b1, 16'h0040});
    end
    bus.mem_ready = 1; bus.mem_rdata = 16'h0F0F;
    tick();
    bus.mem_ready = 0;
    n_cmp++;
    if ({bus.i_done, bus.i_data, bus.mem_error} !== {1'b1, 16'h0F0F, 1'b1}) begin
      n_err++; $display("FAIL timeout_sticky: got %h want %h", {bus.i_done, bus.i_data, bus.mem_error}, {1'b1, 16'h0F0F, 1'b1});
    end
    tick();
    bus.i_req = 0;
    tick();
  endtask

  task automatic test_idle_ready();
    bus.mem_ready = 1; bus.mem_rdata = 16'hDEAD;
    tick();
    tick();
    bus.mem_ready = 0;
    n_cmp++;
    if ({bus.i_done, bus.d_done, bus.mem_read, bus.i_data} !== {1'b0, 1'b0, 1'b0, 16'h0F0F}) begin
      n_err++; $display("FAIL idle_ready_ignored: got %h want %h",
        {bus.i_done, bus.d_done, bus.mem_read, bus.i_data}, {1'b0, 1'b0, 1'b0, 16'h0F0F});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fetch();
    test_fetch();
    test_stats();
    test_priority();
    test_write_wait();
    test_reset_mid();
    test_timeout();
    test_idle_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the IF stage (instruction fetch) and the MEM stage (data load/store).
- Runs one transaction at a time with a ready-based handshake to memory.
- Returns read data to the requester and drives per-requester stall lines into the pipeline control, alongside the hazard stall logic.
- Data accesses have priority over fetches, because the MEM-stage instruction is older.

Parameters:
- WORD_W, 16, data word width.
- ADDR_W, 16, address width.
- TIMEOUT, 64, maximum cycles to wait for mem_ready before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  ADDR_W  fetch address.
- d_read  in  1  data load request; held until d_done.
- d_write  in  1  data store request; held until d_done. Never asserted together with d_read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  WORD_W  store data.
- mem_ready  in  1  memory has completed the current access; for reads, mem_rdata is valid in the same cycle.
- mem_rdata  in  WORD_W  memory read data.
- mem_read  out  1  registered read strobe.
- mem_write  out  1  registered write strobe.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  WORD_W  registered write data; 0 when not writing.
- i_data  out  WORD_W  fetched instruction; valid when i_done.
- d_rdata  out  WORD_W  load data; valid when d_done.
- i_done  out  1  one-cycle completion pulse for fetch.
- d_done  out  1  one-cycle completion pulse for a data access.
- i_stall  out  1  combinational: i_req & ~i_done.
- d_stall  out  1  combinational: (d_read | d_write) & ~d_done.
- mem_error  out  1  sticky timeout flag.

Behaviour:
- Reset values: all registered outputs 0; state IDLE; timeout counter 0.
- States: IDLE, D_BUSY, I_BUSY.
- IDLE:
  - If d_read|d_write is high: latch d_addr (and d_wdata for a write), set mem_read or mem_write, go to D_BUSY.
  - Else if i_req is high: latch i_addr, set mem_read, go to I_BUSY.
  - Else stay in IDLE.
  - Strobes become visible the cycle after the request is first seen in IDLE.
- D_BUSY / I_BUSY:
  - Strobes, address and write data stay stable until mem_ready is sampled high.
  - On that edge: capture mem_rdata into d_rdata or i_data (reads only), pulse d_done or i_done for exactly one cycle, clear strobes and mem_wdata, return to IDLE.
- Minimum transaction: request cycle, then the strobe cycle with mem_ready. Strobes are low for at least one cycle between transactions.
- Simultaneous requests: the data access wins; the fetch is served in the next IDLE arbitration. A fetch is never preempted once it has issued.
- Request dropped mid-transaction: the transaction still completes; the done pulse is emitted and ignored.
- mem_ready while IDLE: ignored.
- Timeout:
  - The counter clears at issue and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT-1, abort: set mem_error (sticky until reset), clear strobes, pulse done with the read-data output set to 0, return to IDLE.
- Reset mid-transaction: strobes drop immediately (asynchronous); no done pulse.
- i_done and d_done are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, add outputs num_i_stall and num_d_stall (16-bit each).
  - Each counts cycles in which the corresponding stall is high.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- i_req=1, i_addr=16'h0010, mem_ready high on the first strobe cycle with mem_rdata=16'h6A05 -> mem_read=1 and mem_addr=16'h0010 for 1 cycle; i_done pulses; i_data=16'h6A05; i_stall high for 2 cycles.
- i_req and d_read (d_addr=16'h0080) asserted in the same cycle -> the data access issues first (mem_addr=16'h0080); the fetch issues in the IDLE cycle after d_done; d_stall and i_stall behave as specified.
- d_write=1, d_addr=16'h0042, d_wdata=16'hBEEF, mem_ready delayed 3 cycles -> mem_write, mem_addr and mem_wdata held stable for 4 cycles; d_done pulses once; mem_wdata returns to 0.
- TIMEOUT=8, i_req held, mem_ready never asserted -> abort after 8 BUSY cycles; mem_error=1; i_done pulses with i_data=0; mem_error stays 1 across later successful transactions.
- reset asserted during D_BUSY -> mem_read/mem_write drop asynchronously; no d_done; after release, the held request re-issues from IDLE.
- With MEM_ARB_STATS_EN: run the first scenario twice -> num_i_stall=4, num_d_stall=0.
